tx_sched: RTL

Transmit scheduler that shares the single USB transmit byte path between two packet sources: the handshake responder (hs) and the encrypted-data path (dp). It arbitrates requests and validates each packet's PID and length. It then sequences SYNC, PID, payload bytes and EOP into the byte transmitter under a valid/ready handshake, and enforces an inter-packet gap before the next grant.

---
 rtl/tx_sched_if.sv | 28 ++
 rtl/tx_sched.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_sched_if.sv
// Byte-transmitter link between the transmit scheduler and the USB byte
// transmitter: one byte per valid/ready handshake, a one-cycle EOP request,
// and the transmitter's line-idle status.
interface tx_sched_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_eop;
    logic       tx_idle;

    // Scheduler side: drives bytes and EOP, observes ready and idle.
    modport master (
        output tx_data,
        output tx_valid,
        output tx_eop,
        input  tx_ready,
        input  tx_idle
    );

    // Transmitter side.
    modport slave (
        input  tx_data,
        input  tx_valid,
        input  tx_eop,
        output tx_ready,
        output tx_idle
    );
endinterface

// File: rtl/tx_sched.sv
// Transmit scheduler: arbitrates the handshake responder (hs) and the
// encrypted-data path (dp) onto the single USB byte transmitter. A granted
// packet is screened (PID complement check, payload length limit), then sent
// as SYNC, PID, payload bytes and an EOP request. After the line returns to
// idle an inter-packet gap is enforced before the next arbitration. hs has
// priority, but dp is forced through after MAX_DEFER consecutive hs grants
// taken while dp was waiting.
module tx_sched #(
    parameter int GAP_CYCLES  = 16,
    parameter int PAYLOAD_MAX = 64,
    parameter int MAX_DEFER   = 3
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             hs_req,
    input  logic [7:0]       hs_pid,
    input  logic [6:0]       hs_len,
    input  logic [7:0]       hs_data,
    output logic             hs_gnt,
    output logic             hs_pop,
    output logic             hs_done,

    input  logic             dp_req,
    input  logic [7:0]       dp_pid,
    input  logic [6:0]       dp_len,
    input  logic [7:0]       dp_data,
    output logic             dp_gnt,
    output logic             dp_pop,
    output logic             dp_done,

    tx_sched_if.master       tx,

    output logic             req_err,
    output logic             busy
);

    // The defer counter must reach MAX_DEFER and never be narrower than 2 bits.
    localparam int DEFER_W = ($clog2(MAX_DEFER + 1) < 2) ? 2 : $clog2(MAX_DEFER + 1);
    localparam int GAP_W   = ($clog2(GAP_CYCLES + 1) < 1) ? 1 : $clog2(GAP_CYCLES + 1);

    localparam logic [DEFER_W-1:0] DEFER_LIM = DEFER_W'(MAX_DEFER);
    localparam logic [GAP_W-1:0]   GAP_LOAD  = GAP_W'(GAP_CYCLES);
    localparam logic [6:0]         LEN_LIM   = 7'(PAYLOAD_MAX);
    localparam logic [7:0]         SYNC_BYTE = 8'h80;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SYNC,
        PID,
        DATA,
        EOP,
        WAIT_IDLE,
        GAP
    } state_t;

    state_t               state_q,  state_d;
    logic                 hs_gnt_q, hs_gnt_d;
    logic                 dp_gnt_q, dp_gnt_d;
    logic                 hs_done_q, hs_done_d;
    logic                 dp_done_q, dp_done_d;
    logic                 req_err_q, req_err_d;
    logic                 tx_eop_q, tx_eop_d;
    logic [7:0]           pid_q,    pid_d;
    logic [6:0]           len_q,    len_d;
    logic [6:0]           byte_q,   byte_d;
    logic [GAP_W-1:0]     gap_q,    gap_d;
    logic [DEFER_W-1:0]   defer_q,  defer_d;

    logic                 dp_wins;
    logic                 pkt_ok;
    logic                 close_pkt;

    // A valid USB PID carries its own one's complement in the upper nibble.
    function automatic logic pid_valid(input logic [7:0] pid);
        return pid[3:0] == ~pid[7:4];
    endfunction

    // dp takes the slot when hs is silent, or when hs has already been
    // favoured MAX_DEFER times in a row while dp was waiting.
    assign dp_wins = dp_req && (!hs_req || (defer_q == DEFER_LIM));
    assign pkt_ok  = pid_valid(pid_q) && (len_q <= LEN_LIM);

    // Next-state and registered-output computation for the packet sequencer.
    always_comb begin
        state_d   = state_q;
        hs_gnt_d  = hs_gnt_q;
        dp_gnt_d  = dp_gnt_q;
        pid_d     = pid_q;
        len_d     = len_q;
        byte_d    = byte_q;
        gap_d     = gap_q;
        defer_d   = defer_q;
        hs_done_d = 1'b0;
        dp_done_d = 1'b0;
        req_err_d = 1'b0;
        tx_eop_d  = 1'b0;
        close_pkt = 1'b0;

        case (state_q)
            IDLE: begin
                if ((gap_q == '0) && tx.tx_idle) begin
                    if (dp_wins) begin
                        dp_gnt_d = 1'b1;
                        pid_d    = dp_pid;
                        len_d    = dp_len;
                        byte_d   = dp_len;
                        defer_d  = '0;
                        state_d  = CHECK;
                    end else if (hs_req) begin
                        hs_gnt_d = 1'b1;
                        pid_d    = hs_pid;
                        len_d    = hs_len;
                        byte_d   = hs_len;
                        // Only grants that actually kept dp waiting count.
                        if (dp_req) begin
                            if (defer_q != DEFER_LIM) begin
                                defer_d = defer_q + 1'b1;
                            end
                        end else begin
                            defer_d = '0;
                        end
                        state_d  = CHECK;
                    end
                end
            end

            CHECK: begin
                if (pkt_ok) begin
                    state_d = SYNC;
                end else begin
                    // Rejected packets release the path at once, with no gap.
                    req_err_d = 1'b1;
                    hs_done_d = hs_gnt_q;
                    dp_done_d = dp_gnt_q;
                    hs_gnt_d  = 1'b0;
                    dp_gnt_d  = 1'b0;
                    state_d   = IDLE;
                end
            end

            SYNC: begin
                if (tx.tx_ready) begin
                    state_d = PID;
                end
            end

            PID: begin
                if (tx.tx_ready) begin
                    if (len_q != 7'd0) begin
                        state_d = DATA;
                    end else begin
                        tx_eop_d = 1'b1;
                        state_d  = EOP;
                    end
                end
            end

            DATA: begin
                if (tx.tx_ready) begin
                    byte_d = byte_q - 7'd1;
                    if (byte_q == 7'd1) begin
                        tx_eop_d = 1'b1;
                        state_d  = EOP;
                    end
                end
            end

            EOP: begin
                // A line that is already idle costs no extra WAIT_IDLE cycle.
                if (tx.tx_idle) begin
                    close_pkt = 1'b1;
                end else begin
                    state_d = WAIT_IDLE;
                end
            end

            WAIT_IDLE: begin
                if (tx.tx_idle) begin
                    close_pkt = 1'b1;
                end
            end

            GAP: begin
                if (gap_q <= GAP_W'(1)) begin
                    gap_d   = '0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (close_pkt) begin
            hs_done_d = hs_gnt_q;
            dp_done_d = dp_gnt_q;
            hs_gnt_d  = 1'b0;
            dp_gnt_d  = 1'b0;
            gap_d     = GAP_LOAD;
            state_d   = (GAP_LOAD == '0) ? IDLE : GAP;
        end
    end

    // Byte presented to the transmitter and payload pops, straight from the
    // current state so back-to-back bytes need no bubble.
    always_comb begin
        tx.tx_valid = 1'b0;
        tx.tx_data  = 8'h00;
        hs_pop      = 1'b0;
        dp_pop      = 1'b0;
        case (state_q)
            SYNC: begin
                tx.tx_valid = 1'b1;
                tx.tx_data  = SYNC_BYTE;
            end
            PID: begin
                tx.tx_valid = 1'b1;
                tx.tx_data  = pid_q;
            end
            DATA: begin
                tx.tx_valid = 1'b1;
                tx.tx_data  = dp_gnt_q ? dp_data : hs_data;
                hs_pop      = hs_gnt_q & tx.tx_ready;
                dp_pop      = dp_gnt_q & tx.tx_ready;
            end
            default: begin
            end
        endcase
    end

    // Sequencer state, latched packet header, counters and registered pulses;
    // reset aborts any packet in flight without done, eop or err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            hs_gnt_q  <= 1'b0;
            dp_gnt_q  <= 1'b0;
            hs_done_q <= 1'b0;
            dp_done_q <= 1'b0;
            req_err_q <= 1'b0;
            tx_eop_q  <= 1'b0;
            pid_q     <= 8'h00;
            len_q     <= 7'd0;
            byte_q    <= 7'd0;
            gap_q     <= '0;
            defer_q   <= '0;
        end else begin
            state_q   <= state_d;
            hs_gnt_q  <= hs_gnt_d;
            dp_gnt_q  <= dp_gnt_d;
            hs_done_q <= hs_done_d;
            dp_done_q <= dp_done_d;
            req_err_q <= req_err_d;
            tx_eop_q  <= tx_eop_d;
            pid_q     <= pid_d;
            len_q     <= len_d;
            byte_q    <= byte_d;
            gap_q     <= gap_d;
            defer_q   <= defer_d;
        end
    end

    assign hs_gnt    = hs_gnt_q;
    assign dp_gnt    = dp_gnt_q;
    assign hs_done   = hs_done_q;
    assign dp_done   = dp_done_q;
    assign req_err   = req_err_q;
    assign tx.tx_eop = tx_eop_q;
    assign busy      = (state_q != IDLE);

endmodule
